cga_text_fetch: RTL and testbench

Text-mode character fetch and pixel serializer for the CGA video path. It sits directly downstream of the 16 KiB dual-port video RAM and reads character and attribute bytes through the RAM's second port. It looks up glyph rows in an external 8x8 font ROM and emits one 4-bit colour index per pixel-clock enable. The CPU side keeps exclusive use of the RAM's first port.

---
 rtl/cga_text_fetch_pkg.sv | 23 ++
 rtl/cga_pixel_shift.sv | 94 +++++++++
 rtl/cga_text_fetch.sv | 123 ++++++++++++
 tb/tb_cga_text_fetch.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cga_text_fetch_pkg.sv
// Shared definitions for the CGA text-mode fetch path.
package cga_text_fetch_pkg;

    localparam int unsigned VRAM_AW = 15;
    localparam int unsigned TEXT_WA = 13;
    localparam int unsigned FONT_AW = 11;
    localparam int unsigned COLOR_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHAR,
        ST_ATTR,
        ST_FONT,
        ST_LATCH
    } fetch_state_t;

    typedef struct packed {
        logic [7:0] glyph;
        logic [7:0] attr;
        logic       cursor;
    } cell_t;

endpackage

// File: rtl/cga_pixel_shift.sv
// Holding register, 8-pixel shifter and colour/cursor/blink selection.
module cga_pixel_shift
    import cga_text_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               load,
    input  logic [7:0]         glyph,
    input  logic [7:0]         attr,
    input  logic               cursor,
    input  logic               pix_ce,
    input  logic               de,
    input  logic               blink_en,
    input  logic               blink_phase,
    output logic               hold_full,
    output logic [COLOR_W-1:0] pixel,
    output logic               pix_valid,
    output logic               underrun
);

    cell_t              hold_q;
    logic [7:0]         shift_q;
    logic [3:0]         cnt_q;
    logic [COLOR_W-1:0] fg_q;
    logic [COLOR_W-1:0] bg_q;
    logic               cur_q;
    logic [COLOR_W-1:0] fg;
    logic [COLOR_W-1:0] bg;
    logic               empty;

    // Colours are resolved once per cell, when the shifter loads.
    always_comb begin
        bg = blink_en ? {1'b0, hold_q.attr[6:4]} : hold_q.attr[7:4];
        fg = hold_q.attr[3:0];
        if (blink_en && hold_q.attr[7] && blink_phase) begin
            fg = bg;
        end
    end

    assign empty = (cnt_q == 4'd0);

    // The loading pix_ce already emits the leftmost pixel, so 7 bits remain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
            shift_q   <= '0;
            cnt_q     <= '0;
            fg_q      <= '0;
            bg_q      <= '0;
            cur_q     <= 1'b0;
            pixel     <= '0;
            pix_valid <= 1'b0;
            underrun  <= 1'b0;
        end else if (clear) begin
            hold_full <= 1'b0;
            cnt_q     <= '0;
            underrun  <= 1'b0;
        end else begin
            if (load) begin
                hold_q.glyph  <= glyph;
                hold_q.attr   <= attr;
                hold_q.cursor <= cursor;
                hold_full     <= 1'b1;
            end
            if (pix_ce) begin
                if (!de) begin
                    pixel     <= '0;
                    pix_valid <= 1'b0;
                end else if (!empty) begin
                    pixel     <= (cur_q || shift_q[7]) ? fg_q : bg_q;
                    pix_valid <= 1'b1;
                    shift_q   <= shift_q << 1;
                    cnt_q     <= cnt_q - 4'd1;
                end else if (hold_full) begin
                    pixel     <= (hold_q.cursor || hold_q.glyph[7]) ? fg : bg;
                    pix_valid <= 1'b1;
                    shift_q   <= {hold_q.glyph[6:0], 1'b0};
                    cnt_q     <= 4'd7;
                    fg_q      <= fg;
                    bg_q      <= bg;
                    cur_q     <= hold_q.cursor;
                    hold_full <= 1'b0;
                end else begin
                    pixel     <= '0;
                    pix_valid <= 1'b1;
                    underrun  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cga_text_fetch.sv
// CGA text-mode character/attribute/font fetch feeding the pixel serializer.
module cga_text_fetch
    import cga_text_fetch_pkg::*;
#(
    parameter int unsigned COLS = 80
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                pix_ce,
    input  logic                line_start,
    input  logic [TEXT_WA-1:0]  row_addr,
    input  logic [2:0]          scan_line,
    input  logic                de,
    input  logic                blink_en,
    input  logic                blink_phase,
    input  logic [TEXT_WA-1:0]  cursor_addr,
    input  logic                cursor_vis,
    output logic                enb,
    output logic                web,
    output logic [VRAM_AW-1:0]  addrb,
    input  logic [7:0]          doutb,
    output logic [FONT_AW-1:0]  font_addr,
    input  logic [7:0]          font_data,
    output logic [COLOR_W-1:0]  pixel,
    output logic                pix_valid,
    output logic                underrun
);

    localparam int unsigned COL_W = $clog2(COLS + 1);

    fetch_state_t       state_q;
    fetch_state_t       state_d;
    logic [COL_W-1:0]   col_q;
    logic [COL_W-1:0]   col_d;
    logic               armed_q;
    logic [7:0]         attr_q;
    logic               hold_full;
    logic               hold_load;
    logic               hit;
    logic [TEXT_WA-1:0] cell_cur;
    logic [TEXT_WA-1:0] cell_nxt;

    assign web = 1'b0;

    // Next state; line_start overrides everything and discards a partial fetch.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        hold_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (armed_q && (col_q < COL_W'(COLS)) && !hold_full) begin
                    state_d = ST_CHAR;
                end
            end
            ST_CHAR:  state_d = ST_ATTR;
            ST_ATTR:  state_d = ST_FONT;
            ST_FONT:  state_d = ST_LATCH;
            ST_LATCH: begin
                state_d   = ST_IDLE;
                hold_load = 1'b1;
                col_d     = col_q + COL_W'(1);
            end
            default:  state_d = ST_IDLE;
        endcase
        if (line_start) begin
            state_d   = ST_CHAR;
            col_d     = '0;
            hold_load = 1'b0;
        end
        cell_cur = row_addr + TEXT_WA'(col_q);
        cell_nxt = row_addr + TEXT_WA'(col_d);
        hit      = cursor_vis && (cell_cur == cursor_addr);
    end

    // VRAM/font addresses are registered from the upcoming state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            armed_q   <= 1'b0;
            attr_q    <= '0;
            enb       <= 1'b0;
            addrb     <= '0;
            font_addr <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            if (line_start) begin
                armed_q <= 1'b1;
            end
            enb <= (state_d == ST_CHAR) || (state_d == ST_ATTR);
            if ((state_d == ST_CHAR) || (state_d == ST_ATTR)) begin
                addrb <= {1'b0, cell_nxt, state_d == ST_ATTR};
            end
            if ((state_q == ST_ATTR) && !line_start) begin
                font_addr <= {doutb, scan_line};
            end
            if (state_q == ST_FONT) begin
                attr_q <= doutb;
            end
        end
    end

    cga_pixel_shift u_shift (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (line_start),
        .load        (hold_load),
        .glyph       (font_data),
        .attr        (attr_q),
        .cursor      (hit),
        .pix_ce      (pix_ce),
        .de          (de),
        .blink_en    (blink_en),
        .blink_phase (blink_phase),
        .hold_full   (hold_full),
        .pixel       (pixel),
        .pix_valid   (pix_valid),
        .underrun    (underrun)
    );

endmodule

// File: tb/tb_cga_text_fetch.sv
// Self-checking bench for cga_text_fetch with behavioural VRAM, font ROM and pixel model.
module tb_cga_text_fetch;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_ce = 1'b0;
    logic        line_start = 1'b0;
    logic [12:0] row_addr = '0;
    logic [2:0]  scan_line = '0;
    logic        de = 1'b0;
    logic        blink_en = 1'b0;
    logic        blink_phase = 1'b0;
    logic [12:0] cursor_addr = '0;
    logic        cursor_vis = 1'b0;
    logic        enb;
    logic        web;
    logic [14:0] addrb;
    logic [7:0]  doutb = '0;
    logic [10:0] font_addr;
    logic [7:0]  font_data = '0;
    logic [3:0]  pixel;
    logic        pix_valid;
    logic        underrun;

    cga_text_fetch #(.COLS(80)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_ce      (pix_ce),
        .line_start  (line_start),
        .row_addr    (row_addr),
        .scan_line   (scan_line),
        .de          (de),
        .blink_en    (blink_en),
        .blink_phase (blink_phase),
        .cursor_addr (cursor_addr),
        .cursor_vis  (cursor_vis),
        .enb         (enb),
        .web         (web),
        .addrb       (addrb),
        .doutb       (doutb),
        .font_addr   (font_addr),
        .font_data   (font_data),
        .pixel       (pixel),
        .pix_valid   (pix_valid),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    logic [7:0] vram [0:16383];
    logic [7:0] font [0:2047];

    always @(posedge clk) if (enb) doutb <= vram[addrb[13:0]];
    always @(posedge clk) font_data <= font[font_addr];

    int          n_checks = 0;
    int          n_pass = 0;
    int          bad_valid = 0;
    logic        collect = 1'b0;
    logic [3:0]  got_q[$];
    logic [14:0] fetch_q[$];
    logic [31:0] got_cell [0:127];

    typedef struct {
        logic [7:0]  attr;
        logic [7:0]  glyph;
        logic        ben;
        logic        bph;
        logic        cur;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [0:9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // One clock: sample outputs #1 after the edge and log VRAM reads / consumed pixels.
    task automatic tick();
        logic used;
        used = pix_ce & de;
        @(posedge clk);
        #1;
        if (enb) fetch_q.push_back(addrb);
        if (collect && used) begin
            got_q.push_back(pixel);
            if (pix_valid !== 1'b1) bad_valid++;
        end
    endtask

    // Expected 8 pixels of cell c, leftmost in the top nibble.
    function automatic logic [31:0] model_cell(input int c);
        int a, ch, at, g, fg, bg, p;
        logic hit;
        logic [31:0] r;
        a  = (int'(row_addr) + c) % 8192;
        ch = int'(vram[2 * a]);
        at = int'(vram[2 * a + 1]);
        g  = int'(font[ch * 8 + int'(scan_line)]);
        fg = at % 16;
        bg = blink_en ? (at / 16) % 8 : at / 16;
        if (blink_en && at >= 128 && blink_phase) fg = bg;
        hit = cursor_vis && (a == int'(cursor_addr));
        r = '0;
        for (int i = 0; i < 8; i++) begin
            p = (hit || (((g >> (7 - i)) & 1) == 1)) ? fg : bg;
            r = (r << 4) | 32'(p);
        end
        return r;
    endfunction

    task automatic run_line(input int ncell, input bit fast, input string tag);
        int budget;
        logic [31:0] w;
        got_q.delete();
        fetch_q.delete();
        bad_valid = 0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        collect = 1'b1;
        repeat (6) tick();
        budget = 0;
        while (got_q.size() < ncell * 8 && budget < 6000) begin
            de = fast ? 1'b1 : ($urandom_range(0, 7) != 0);
            pix_ce = fast ? 1'b1 : ($urandom_range(0, 2) != 0);
            tick();
            budget++;
        end
        de = 1'b0;
        pix_ce = 1'b0;
        collect = 1'b0;
        check({tag, "_count"}, 32'(got_q.size()), 32'(ncell * 8));
        for (int c = 0; c < ncell; c++) begin
            if (got_q.size() >= (c + 1) * 8) begin
                w = '0;
                for (int j = 0; j < 8; j++) w = (w << 4) | 32'(got_q[c * 8 + j]);
                got_cell[c] = w;
                check($sformatf("%s_cell%0d", tag, c), w, model_cell(c));
            end
        end
        check({tag, "_valid"}, 32'(bad_valid), 32'd0);
        check({tag, "_underrun"}, 32'(underrun), 32'd0);
    endtask

    initial begin
        int evens, guard;

        vecs[0] = '{8'h1E, 8'hF0, 1'b0, 1'b0, 1'b0, 32'hEEEE1111};
        vecs[1] = '{8'h8F, 8'hFF, 1'b1, 1'b1, 1'b0, 32'h00000000};
        vecs[2] = '{8'h8F, 8'hFF, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF};
        vecs[3] = '{8'h8F, 8'hFF, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF};
        vecs[4] = '{8'h07, 8'h00, 1'b0, 1'b0, 1'b1, 32'h77777777};
        vecs[5] = '{8'h07, 8'h00, 1'b0, 1'b0, 1'b0, 32'h00000000};
        vecs[6] = '{8'h8F, 8'h0F, 1'b0, 1'b0, 1'b0, 32'h8888FFFF};
        vecs[7] = '{8'h3C, 8'hA5, 1'b1, 1'b1, 1'b0, 32'hC3C33C3C};
        vecs[8] = '{8'hC5, 8'h81, 1'b1, 1'b1, 1'b1, 32'h44444444};
        vecs[9] = '{8'hC5, 8'h81, 1'b0, 1'b0, 1'b0, 32'h5CCCCCC5};

        for (int i = 0; i < 16384; i++) vram[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) font[i] = 8'($urandom);

        // Reset values
        repeat (2) tick();
        check("rst_enb", 32'(enb), 0);
        check("rst_web", 32'(web), 0);
        check("rst_addrb", 32'(addrb), 0);
        check("rst_font_addr", 32'(font_addr), 0);
        check("rst_pixel", 32'(pixel), 0);
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_underrun", 32'(underrun), 0);
        reset_n = 1'b1;
        fetch_q.delete();
        repeat (10) tick();
        check("idle_no_fetch", 32'(fetch_q.size()), 0);

        // Basic fetch: address sequence and font address
        row_addr = '0;
        scan_line = 3'd3;
        vram[0] = 8'h41;
        vram[1] = 8'h1E;
        font[11'h20B] = 8'hF0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        check("basic_addr0", {16'(enb), 16'(addrb)}, {16'd1, 16'h0000});
        tick();
        check("basic_addr1", {16'(enb), 16'(addrb)}, {16'd1, 16'h0001});
        tick();
        check("basic_font_addr", 32'(font_addr), 32'h20B);
        run_line(1, 1'b1, "basic");
        check("basic_pixels", got_cell[0], 32'hEEEE1111);

        // Table of colour/blink/cursor vectors on cell 0
        scan_line = 3'd5;
        for (int v = 0; v < 10; v++) begin
            vram[0] = 8'h10;
            vram[1] = vecs[v].attr;
            font[8'h10 * 8 + 5] = vecs[v].glyph;
            blink_en = vecs[v].ben;
            blink_phase = vecs[v].bph;
            cursor_vis = vecs[v].cur;
            cursor_addr = vecs[v].cur ? 13'd0 : 13'h100;
            run_line(1, 1'b1, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_table", v), got_cell[0], vecs[v].exp);
        end

        // Cursor on cell 5 with blank neighbours
        blink_en = 1'b0;
        blink_phase = 1'b0;
        scan_line = 3'd2;
        for (int c = 0; c < 8; c++) begin
            vram[2 * c] = 8'h00;
            vram[2 * c + 1] = 8'h07;
        end
        font[2] = 8'h00;
        cursor_addr = 13'd5;
        cursor_vis = 1'b1;
        run_line(8, 1'b0, "cursor");
        check("cursor_cell4", got_cell[4], 32'h00000000);
        check("cursor_cell5", got_cell[5], 32'h77777777);
        check("cursor_cell6", got_cell[6], 32'h00000000);

        // Address wrap across the top of VRAM, full line with pix_ce tied high
        for (int i = 0; i < 16384; i++) vram[i] = 8'($urandom);
        row_addr = 13'h1FFF;
        cursor_addr = 13'd3;
        run_line(80, 1'b1, "wrap");
        repeat (20) tick();
        evens = 0;
        foreach (fetch_q[i]) if (fetch_q[i][0] == 1'b0) evens++;
        check("wrap_fetches", 32'(evens), 32'd80);
        check("wrap_a0", 32'(fetch_q[0]), 32'h3FFE);
        check("wrap_a2", 32'(fetch_q[2]), 32'h0000);
        check("wrap_a3", 32'(fetch_q[3]), 32'h0001);

        // Randomized lines against the model
        for (int l = 0; l < 3; l++) begin
            row_addr = 13'($urandom);
            scan_line = 3'($urandom);
            blink_en = 1'($urandom);
            blink_phase = 1'($urandom);
            cursor_vis = 1'($urandom);
            cursor_addr = row_addr + 13'($urandom_range(0, 79));
            run_line(80, 1'b0, $sformatf("rand%0d", l));
        end

        // Underrun when de follows line_start too closely, then mid-fetch restart
        row_addr = 13'h0123;
        cursor_vis = 1'b0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        de = 1'b1;
        pix_ce = 1'b1;
        tick();
        check("urun_flag", 32'(underrun), 1);
        check("urun_pixel", {16'(pix_valid), 16'(pixel)}, {16'd1, 16'd0});
        repeat (9) tick();
        guard = 0;
        while (!(enb && addrb[0]) && guard < 40) begin
            tick();
            guard++;
        end
        check("urun_find_attr", 32'(guard < 40), 1);
        de = 1'b0;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        pix_ce = 1'b0;
        check("restart_underrun", 32'(underrun), 0);
        check("restart_addr", {16'(enb), 16'(addrb)}, {16'd1, 16'h0246});

        // Reset during ATTR
        repeat (10) tick();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        de = 1'b1;
        pix_ce = 1'b1;
        guard = 0;
        while (!(enb && addrb[0]) && guard < 20) begin
            tick();
            guard++;
        end
        check("rstmid_find_attr", 32'(guard < 20), 1);
        reset_n = 1'b0;
        tick();
        check("rstmid_enb", 32'(enb), 0);
        check("rstmid_pix_valid", 32'(pix_valid), 0);
        reset_n = 1'b1;
        de = 1'b0;
        pix_ce = 1'b0;
        fetch_q.delete();
        repeat (20) tick();
        check("rstmid_no_fetch", 32'(fetch_q.size()), 0);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        check("rstmid_relaunch", {16'(enb), 16'(addrb)}, {16'd1, 16'h0246});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
